// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed seven-segment scan controller with frame-synchronous commit
// Shadow buffer is written through a valid/ready port and copied to the displayed set only at frame boundaries.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int AW           = 2
) (
  input  logic                  CLOCK_50,
  input  logic                  RST_N,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [AW-1:0]         wr_addr,
  input  logic [3:0]            wr_data,
  input  logic                  upd,
  input  logic                  lzb_en,
  output logic [0:6]            SEG,
  output logic [NUM_DIGITS-1:0] DIG_N,
  output logic [AW-1:0]         scan_idx,
  output logic                  frame_done
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [AW-1:0] LAST_DIGIT = AW'(NUM_DIGITS - 1);
  localparam logic [0:6]    SEG_OFF    = 7'b1111111;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   scan_q, scan_d;
  logic            pend_q, pend_d;
  logic            ready_q;
  logic            fd_q;
  logic            boundary;
  logic [0:6]      seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dign_q, dign_d;
  logic [3:0]      shadow [NUM_DIGITS];
  logic [3:0]      active [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_blank;
  logic            zero_run;
  logic [3:0]      cur_val;
  logic            cur_blank;
  logic            wr_fire;

  function automatic logic [0:6] glyph(input logic [3:0] v);
    logic [0:6] g;
    case (v)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    return g;
  endfunction

  assign wr_fire = wr_valid & ready_q;

  // A digit above 0 is a leading zero when it and every more significant digit are 0.
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run & (active[i] == 4'd0);
      lz_blank[i] = zero_run;
    end
  end

  always_comb begin
    cur_val   = 4'd0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_q == AW'(i)) begin
        cur_val   = active[i];
        cur_blank = lz_blank[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    scan_d   = scan_q;
    boundary = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (scan_q == LAST_DIGIT) begin
            scan_d   = '0;
            boundary = 1'b1;
          end else begin
            scan_d = scan_q + 1'b1;
          end
        end
      end
    endcase

    // A request seen while one is pending is dropped; one seen on the boundary waits a frame.
    pend_d = pend_q ? !boundary : upd;

    seg_d  = SEG_OFF;
    dign_d = '1;
    if (state_d == ST_SHOW) begin
      seg_d = (lzb_en && cur_blank) ? SEG_OFF : glyph(cur_val);
      for (int i = 0; i < NUM_DIGITS; i++) begin
        dign_d[i] = !(scan_q == AW'(i));
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      scan_q  <= '0;
      pend_q  <= 1'b0;
      ready_q <= 1'b1;
      fd_q    <= 1'b0;
      seg_q   <= SEG_OFF;
      dign_q  <= '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= 4'd0;
        active[i] <= 4'd0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scan_q  <= scan_d;
      pend_q  <= pend_d;
      ready_q <= !pend_d;
      fd_q    <= boundary;
      seg_q   <= seg_d;
      dign_q  <= dign_d;
      // Out-of-range addresses match no slot and are silently dropped.
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_fire && wr_addr == AW'(i)) begin
          shadow[i] <= wr_data;
        end
      end
      if (boundary && pend_q) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          active[i] <= shadow[i];
        end
      end
    end
  end

  assign wr_ready   = ready_q;
  assign SEG        = seg_q;
  assign DIG_N      = dign_q;
  assign scan_idx   = scan_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed self-checking bench for seg7_scan_ctrl
// Four digits, dwell 4, blank 2: a 24-cycle frame; pos tracks the cycle within the frame (1..24).
module tb_seg7_scan_ctrl;

  localparam logic [6:0] G0 = 7'b0000001;
  localparam logic [6:0] G3 = 7'b0000110;
  localparam logic [6:0] G5 = 7'b0100100;
  localparam logic [6:0] G7 = 7'b0001111;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GE = 7'b0110000;
  localparam logic [6:0] GF = 7'b0111000;
  localparam logic [6:0] BL = 7'b1111111;

  logic       CLOCK_50 = 1'b0;
  logic       RST_N;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       upd;
  logic       lzb_en;
  logic [0:6] SEG;
  logic [3:0] DIG_N;
  logic [2:0] scan_idx;
  logic       frame_done;

  int checks = 0;
  int errors = 0;
  int pos    = 0;
  int frame  = 1;

  seg7_scan_ctrl #(
    .NUM_DIGITS(4),
    .DWELL_CYCLES(4),
    .BLANK_CYCLES(2),
    .AW(3)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RST_N(RST_N),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .upd(upd),
    .lzb_en(lzb_en),
    .SEG(SEG),
    .DIG_N(DIG_N),
    .scan_idx(scan_idx),
    .frame_done(frame_done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLOCK_50);
    if (pos == 24) begin
      pos = 1;
      frame++;
    end else begin
      pos++;
    end
  endtask

  task automatic wait_pos(input int p);
    while (pos != p) step();
  endtask

  // Walks one full frame from pos 1, checking scan order, blanking gaps and glyphs.
  task automatic check_frame(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic fd_first);
    logic [6:0] g [4];
    g = '{s0, s1, s2, s3};
    for (int k = 1; k <= 24; k++) begin
      int d;
      int o;
      logic [3:0] exp_dig;
      logic [6:0] exp_seg;
      d = (k - 1) / 6;
      o = (k - 1) % 6;
      exp_dig = (o < 2) ? 4'b1111 : ~(4'b0001 << d);
      exp_seg = (o < 2) ? BL : g[d];
      chk($sformatf("dig_n f%0d p%0d", frame, k), 32'(DIG_N), 32'(exp_dig));
      chk($sformatf("seg f%0d p%0d", frame, k), 32'(SEG), 32'(exp_seg));
      chk($sformatf("scan_idx f%0d p%0d", frame, k), 32'(scan_idx), 32'(d));
      chk($sformatf("frame_done f%0d p%0d", frame, k), 32'(frame_done),
          (k == 1) ? 32'(fd_first) : 32'd0);
      step();
    end
  endtask

  initial begin
    RST_N    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = 3'd0;
    wr_data  = 4'd0;
    upd      = 1'b0;
    lzb_en   = 1'b0;
    repeat (3) @(negedge CLOCK_50);

    chk("reset seg", 32'(SEG), 32'(BL));
    chk("reset dig_n", 32'(DIG_N), 32'hf);
    chk("reset wr_ready", 32'(wr_ready), 32'd1);
    chk("reset frame_done", 32'(frame_done), 32'd0);
    chk("reset scan_idx", 32'(scan_idx), 32'd0);
    RST_N = 1'b1;
    pos   = 1;

    // 1: idle frame after reset shows zeros on every digit
    check_frame(G0, G0, G0, G0, 1'b0);

    // 2: load 3,A,0,F and commit mid-frame
    chk("t2 ready before writes", 32'(wr_ready), 32'd1);
    wr_valid = 1'b1;
    wr_addr = 3'd0; wr_data = 4'h3; step();
    wr_addr = 3'd1; wr_data = 4'hA; step();
    wr_addr = 3'd2; wr_data = 4'h0; step();
    wr_addr = 3'd3; wr_data = 4'hF; step();
    wr_valid = 1'b0;
    upd = 1'b1; step();
    upd = 1'b0;
    chk("t2 ready low after upd", 32'(wr_ready), 32'd0);
    wait_pos(9);
    chk("t2 old value still shown", 32'(SEG), 32'(G0));
    wait_pos(24);
    chk("t2 ready low at boundary", 32'(wr_ready), 32'd0);
    step();
    chk("t2 ready back after commit", 32'(wr_ready), 32'd1);
    check_frame(G3, GA, G0, GF, 1'b1);

    // 3: 5,0,0,0 with leading-zero blanking on, then off
    wr_valid = 1'b1;
    wr_addr = 3'd0; wr_data = 4'h5; step();
    wr_addr = 3'd1; wr_data = 4'h0; step();
    wr_addr = 3'd2; wr_data = 4'h0; step();
    wr_addr = 3'd3; wr_data = 4'h0; step();
    wr_valid = 1'b0;
    upd = 1'b1; lzb_en = 1'b1; step();
    upd = 1'b0;
    wait_pos(1);
    check_frame(G5, BL, BL, BL, 1'b1);
    lzb_en = 1'b0;
    check_frame(G5, G0, G0, G0, 1'b1);

    // 4: write and upd together, then a write refused while frozen
    wait_pos(2);
    wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 4'h7; upd = 1'b1;
    step();
    upd = 1'b0;
    wr_addr = 3'd3; wr_data = 4'h9;
    chk("t4 ready low after upd", 32'(wr_ready), 32'd0);
    step();
    step();
    wr_valid = 1'b0;
    wait_pos(15);
    chk("t4 digit2 unchanged before boundary", 32'(SEG), 32'(G0));
    wait_pos(20);
    lzb_en = 1'b1;
    wait_pos(1);
    check_frame(G5, G0, G7, BL, 1'b1);

    // 5: upd exactly on the boundary cycle commits one frame later
    wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 4'hE;
    step();
    wr_valid = 1'b0;
    wait_pos(24);
    upd = 1'b1;
    step();
    upd = 1'b0;
    chk("t5 ready low after boundary upd", 32'(wr_ready), 32'd0);
    check_frame(G5, G0, G7, BL, 1'b1);
    chk("t5 ready back after late commit", 32'(wr_ready), 32'd1);
    check_frame(G5, GE, G7, BL, 1'b1);

    // 6: reset during digit 2 with a commit pending
    wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 4'h1;
    step();
    wr_valid = 1'b0;
    upd = 1'b1;
    step();
    upd = 1'b0;
    wait_pos(16);
    chk("t6 digit2 lit before reset", 32'(SEG), 32'(G7));
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    chk("t6 reset seg", 32'(SEG), 32'(BL));
    chk("t6 reset dig_n", 32'(DIG_N), 32'hf);
    chk("t6 reset wr_ready", 32'(wr_ready), 32'd1);
    chk("t6 reset frame_done", 32'(frame_done), 32'd0);
    chk("t6 reset scan_idx", 32'(scan_idx), 32'd0);
    pos = 1;
    wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 4'h9;
    step();
    wr_valid = 1'b0;
    chk("t6 pending commit dropped", 32'(wr_ready), 32'd1);
    wait_pos(1);
    check_frame(G0, BL, BL, BL, 1'b1);
    upd = 1'b1;
    step();
    upd = 1'b0;
    wait_pos(1);
    check_frame(G0, BL, BL, BL, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
